// File: rtl/prog_timer.sv
// prog_timer: programmable down-count timer.
//   A start loads a tick count N (0 is taken as 1) and a one-shot/periodic mode.
//   The count steps down once every PRESCALE clocks. expire pulses for one cycle
//   at the end of each period. hold pauses the prescaler and the count. abort
//   returns the timer to IDLE.
// Ports:
//   clk, rst_n        rising-edge clock, async active-low reset
//   start             load load_val/periodic and (re)start, from any state
//   load_val[W]       tick count N, sampled on start
//   periodic          sampled on start: 1 = auto-reload, 0 = one-shot
//   hold              level; freezes prescaler and count while running
//   abort             cancel the run and return to IDLE (start has priority)
//   expire            1-cycle end-of-period pulse (combinational from regs + hold)
//   done / busy       IDLE / RUN (busy includes held cycles)
//   count[W]          current remaining count
module prog_timer #(
  parameter int W        = 16,
  parameter int PRESCALE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] load_val,
  input  logic         periodic,
  input  logic         hold,
  input  logic         abort,
  output logic         expire,
  output logic         done,
  output logic         busy,
  output logic [W-1:0] count
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]    state;
  logic [W-1:0]  q;
  logic [PW-1:0] p;
  logic [W-1:0]  rld;
  logic          per;

  logic [W-1:0]  ld;
  logic          run;
  logic          tick;

  // A zero load acts as a one-tick period; the max value loads as-is, so no overflow.
  assign ld     = (load_val == '0) ? W'(1) : load_val;
  assign run    = (state == S_RUN);
  // With PRESCALE=1, P_LAST is 0 and p never leaves 0, so every unheld RUN cycle ticks.
  assign tick   = run && !hold && (p == P_LAST);
  assign expire = tick && (q == '0);
  assign done   = (state == S_IDLE);
  assign busy   = run;
  assign count  = q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      q     <= '0;
      p     <= '0;
      rld   <= '0;
      per   <= 1'b0;
    end else if (start) begin
      state <= S_RUN;
      q     <= ld - W'(1);
      rld   <= ld;
      per   <= periodic;
      p     <= '0;
    end else if (abort) begin
      // q and p are left alone so count shows what remained at the abort.
      state <= S_IDLE;
    end else if (run && !hold) begin
      if (!tick) begin
        p <= p + PW'(1);
      end else if (q != '0) begin
        q <= q - W'(1);
        p <= '0;
      end else if (per) begin
        // Reload straight into the next period; there is no dead cycle.
        q <= rld - W'(1);
        p <= '0;
      end else begin
        state <= S_IDLE;
        p     <= '0;
      end
    end
  end

endmodule
